// File: rtl/adder32_seq_pkg.sv
// Shared constants and state encoding for the sequential 32-bit add/subtract unit.
package adder32_seq_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/adder32_seq_ctrl_if.sv
// Start/ready/done handshake and operand/result bus between the control unit
// (master) and the sequential adder (slave).
interface adder32_seq_ctrl_if;
    import adder32_seq_pkg::*;

    logic              start;
    logic              op_sub;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              ready;
    logic              done;
    logic [WORD_W-1:0] result;
    logic              cout;
    logic              ovf;
    logic              zero;

    modport master (
        output start, op_sub, a, b,
        input  ready, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op_sub, a, b,
        output ready, done, result, cout, ovf, zero
    );

endinterface

// File: rtl/adder_16b.sv
// 16-bit carry-lookahead adder slice: four 4-bit groups with a lookahead
// carry unit, exporting group generate/propagate for carry chaining.
module adder_16b
    import adder32_seq_pkg::*;
(
    input  logic [HALF_W-1:0] x,
    input  logic [HALF_W-1:0] y,
    input  logic              cin,
    output logic [HALF_W-1:0] s,
    output logic              gpp,
    output logic              ppp
);

    always_comb begin : cla
        logic [HALF_W-1:0] g;
        logic [HALF_W-1:0] p;
        logic [3:0]        gg;
        logic [3:0]        pg;
        logic [3:0]        gc;
        logic              carry;

        // NOTE: every output gets a value on every path before any branching,
        // so no latch can be inferred.
        s     = '0;
        g     = x & y;
        p     = x ^ y;
        carry = 1'b0;

        for (int i = 0; i < 4; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            pg[i] = &p[4*i +: 4];
        end

        gc[0] = cin;
        gc[1] = gg[0] | (pg[0] & cin);
        gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin);

        for (int i = 0; i < 4; i++) begin
            carry = gc[i];
            for (int j = 0; j < 4; j++) begin
                s[4*i+j] = p[4*i+j] ^ carry;
                carry    = g[4*i+j] | (p[4*i+j] & carry);
            end
        end

        gpp = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
            | (pg[3] & pg[2] & pg[1] & gg[0]);
        ppp = &pg;
    end

endmodule

// File: rtl/adder32_seq_ctrl.sv
// Sequential 32-bit add/subtract: one 16-bit CLA slice used twice (low half,
// then high half with a registered inter-half carry), start/ready/done handshake.
module adder32_seq_ctrl
    import adder32_seq_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    adder32_seq_ctrl_if.slave bus
);

    state_t            state;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] result_q;
    logic              sub_q;
    logic              c16_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;
    logic              done_q;

    logic [HALF_W-1:0] x;
    logic [HALF_W-1:0] y;
    logic [HALF_W-1:0] s;
    logic              cin;
    logic              gpp;
    logic              ppp;

    // Slice inputs are held at zero outside LO/HI so the adder stays quiet when idle.
    always_comb begin
        x   = '0;
        y   = '0;
        cin = 1'b0;
        case (state)
            S_LO: begin
                x   = a_q[HALF_W-1:0];
                y   = b_q[HALF_W-1:0];
                cin = sub_q;
            end
            S_HI: begin
                x   = a_q[WORD_W-1:HALF_W];
                y   = b_q[WORD_W-1:HALF_W];
                cin = c16_q;
            end
            default: ;
        endcase
    end

    adder_16b u_slice (
        .x   (x),
        .y   (y),
        .cin (cin),
        .s   (s),
        .gpp (gpp),
        .ppp (ppp)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c16_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Subtract is A + ~B + 1; the +1 enters as the low-half carry-in.
                        a_q   <= bus.a;
                        b_q   <= bus.op_sub ? ~bus.b : bus.b;
                        sub_q <= bus.op_sub;
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    result_q[HALF_W-1:0] <= s;
                    c16_q                <= gpp | (ppp & sub_q);
                    state                <= S_HI;
                end
                S_HI: begin
                    result_q[WORD_W-1:HALF_W] <= s;
                    cout_q <= gpp | (ppp & c16_q);
                    ovf_q  <= (a_q[WORD_W-1] == b_q[WORD_W-1]) & (s[HALF_W-1] != a_q[WORD_W-1]);
                    zero_q <= (s == '0) & (result_q[HALF_W-1:0] == '0);
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = (state == S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;

endmodule
